// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: a small circular byte FIFO feeding an 8N1 serialiser.
// Bytes are sent LSB first at CLK_DIV clocks per bit, and back-to-back frames
// are sent with no idle gap. Every output is a register or a decode of one.
module uart_tx_ctrl #(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  output logic             fifo_full,
  output logic             fifo_empty,
  output logic [CNT_W-1:0] fifo_count,
  output logic             uart_tx,
  output logic             uart_tx_busy,
  output logic             next_bit
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BAUD_W = $clog2(CLK_DIV);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state, state_n;
  logic [BAUD_W-1:0] baud_cnt, baud_cnt_n;
  logic [2:0]        bit_idx, bit_idx_n;
  logic [7:0]        shift_reg, shift_n;
  logic              tx_n, busy_n, next_bit_n;
  logic              pop, wr_accept, period_end;

  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;

  // Flags are decoded from the registered occupancy, so wr_en never reaches
  // an output combinationally.
  assign fifo_count = count;
  assign fifo_full  = (count == DEPTH_C);
  assign fifo_empty = (count == '0);
  assign wr_accept  = wr_en & ~fifo_full;
  assign period_end = (baud_cnt == BAUD_LAST);

  // FIFO storage: data only, so it is not reset.
  always_ff @(posedge clk) begin
    if (wr_accept)
      fifo_mem[wr_ptr] <= wr_data;
  end

  // FIFO pointers and occupancy. A pop and a write on the same edge leave the count unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_accept)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      if (wr_accept && !pop)
        count <= count + CNT_W'(1);
      else if (!wr_accept && pop)
        count <= count - CNT_W'(1);
    end
  end

  // Next-state, baud counter, shifter and line value for the serialiser.
  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_idx_n  = bit_idx;
    shift_n    = shift_reg;
    tx_n       = uart_tx;
    busy_n     = uart_tx_busy;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        tx_n       = 1'b1;
        busy_n     = 1'b0;
        baud_cnt_n = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_n = fifo_mem[rd_ptr];
          state_n = START;
          tx_n    = 1'b0;
          busy_n  = 1'b1;
        end
      end
      START: begin
        if (period_end) begin
          baud_cnt_n = '0;
          bit_idx_n  = '0;
          state_n    = DATA;
          tx_n       = shift_reg[0];
        end else begin
          baud_cnt_n = baud_cnt + BAUD_W'(1);
        end
      end
      DATA: begin
        if (period_end) begin
          baud_cnt_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            shift_n   = {1'b0, shift_reg[7:1]};
            bit_idx_n = bit_idx + 3'd1;
            tx_n      = shift_reg[1];
          end
        end else begin
          baud_cnt_n = baud_cnt + BAUD_W'(1);
        end
      end
      STOP: begin
        if (period_end) begin
          baud_cnt_n = '0;
          if (!fifo_empty) begin
            // Chain straight into the next start bit; busy stays high.
            pop     = 1'b1;
            shift_n = fifo_mem[rd_ptr];
            state_n = START;
            tx_n    = 1'b0;
          end else begin
            state_n = IDLE;
            busy_n  = 1'b0;
          end
        end else begin
          baud_cnt_n = baud_cnt + BAUD_W'(1);
        end
      end
      default: begin
        state_n    = IDLE;
        baud_cnt_n = '0;
        tx_n       = 1'b1;
        busy_n     = 1'b0;
      end
    endcase
    // The strobe is registered, so it is computed from the counter's next value.
    next_bit_n = (state_n != IDLE) && (baud_cnt_n == BAUD_LAST);
  end

  // FSM and line registers. Reset aborts any frame in progress and idles the line high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      baud_cnt     <= '0;
      bit_idx      <= '0;
      uart_tx      <= 1'b1;
      uart_tx_busy <= 1'b0;
      next_bit     <= 1'b0;
    end else begin
      state        <= state_n;
      baud_cnt     <= baud_cnt_n;
      bit_idx      <= bit_idx_n;
      uart_tx      <= tx_n;
      uart_tx_busy <= busy_n;
      next_bit     <= next_bit_n;
    end
  end

  // Shift register holding the byte in flight: data only, so it is not reset.
  always_ff @(posedge clk) begin
    shift_reg <= shift_n;
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with CLK_DIV=4 and FIFO_DEPTH=8. Line, busy and
// next_bit are logged on every cycle, and frames are decoded from that log by
// sampling each bit at mid-period.
module tb_uart_tx_ctrl;

  localparam int CD    = 4;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int FR    = 10 * CD;
  localparam int LOGN  = 8192;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          fifo_full, fifo_empty, uart_tx, uart_tx_busy, next_bit;
  logic [CW-1:0] fifo_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic       log_tx   [LOGN];
  logic       log_busy [LOGN];
  logic       log_nb   [LOGN];
  logic [7:0] rx_bytes [32];
  int         rx_start [32];
  int         rx_n, rx_badframe;

  uart_tx_ctrl #(.CLK_DIV(CD), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_count(fifo_count),
    .uart_tx(uart_tx), .uart_tx_busy(uart_tx_busy), .next_bit(next_bit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (cyc < LOGN) begin
      log_tx[cyc]   = uart_tx;
      log_busy[cyc] = uart_tx_busy;
      log_nb[cyc]   = next_bit;
      cyc++;
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // Decode every complete 8N1 frame whose start bit lies in log[a, b).
  task automatic decode(input int a, input int b);
    int i;
    logic [7:0] v;
    rx_n = 0;
    rx_badframe = 0;
    i = a;
    while (i + FR <= b) begin
      if (log_tx[i] === 1'b0) begin
        for (int k = 0; k < 8; k++) v[k] = log_tx[i + CD * (k + 1) + CD / 2];
        if (log_tx[i + CD / 2] !== 1'b0 || log_tx[i + 9 * CD + CD / 2] !== 1'b1)
          rx_badframe++;
        if (rx_n < 32) begin
          rx_bytes[rx_n] = v;
          rx_start[rx_n] = i;
          rx_n++;
        end
        i += FR;
      end else begin
        i++;
      end
    end
  endtask

  // Count the logged cycles in [a, b) where the selected signal is high (0=busy, 1=next_bit, 2=line low).
  function automatic int count_hi(input int a, input int b, input int sel);
    int n = 0;
    for (int j = a; j < b; j++) begin
      if (sel == 0 && log_busy[j] === 1'b1) n++;
      if (sel == 1 && log_nb[j] === 1'b1) n++;
      if (sel == 2 && log_tx[j] !== 1'b1) n++;
    end
    return n;
  endfunction

  initial begin
    int s, mism, v, guard, maxocc;
    logic [9:0] t1_seq;
    reset = 1'b1;
    wr_en = 1'b0;
    wr_data = 8'h00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_tx", uart_tx, 1);
    chk("rst_busy", uart_tx_busy, 0);
    chk("rst_next_bit", next_bit, 0);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_full", fifo_full, 0);
    chk("rst_count", fifo_count, 0);
    reset = 1'b0;
    ticks(3);
    chk("idle_tx", uart_tx, 1);
    chk("idle_empty", fifo_empty, 1);

    // Single byte 0xA5; expected line 0,1,0,1,0,0,1,0,1,1 (index 0 first).
    t1_seq = 10'b1101001010;
    s = cyc;
    wr_data = 8'hA5; wr_en = 1'b1; tick(); wr_en = 1'b0;
    chk("t1_tx_after_write_edge", uart_tx, 1);
    chk("t1_count_after_write", fifo_count, 1);
    tick();
    chk("t1_start_low", uart_tx, 0);
    chk("t1_busy_on", uart_tx_busy, 1);
    chk("t1_count_after_pop", fifo_count, 0);
    ticks(50);
    decode(s, cyc);
    chk("t1_frames", rx_n, 1);
    chk("t1_byte", rx_bytes[0], 8'hA5);
    chk("t1_start_index", rx_start[0], s + 1);
    chk("t1_badframe", rx_badframe, 0);
    mism = 0;
    for (int j = 0; j < FR; j++)
      if (log_tx[s + 1 + j] !== t1_seq[j / CD]) mism++;
    chk("t1_line_sequence_mismatches", mism, 0);
    chk("t1_busy_cycles", count_hi(s, cyc, 0), 40);
    chk("t1_next_bit_pulses", count_hi(s, cyc, 1), 10);
    mism = 0;
    for (int j = s; j < cyc; j++)
      if (log_nb[j] === 1'b1 && (j < s + 1 || (j - s - 1) % CD != CD - 1)) mism++;
    chk("t1_next_bit_misplaced", mism, 0);
    chk("t1_idle_tx", uart_tx, 1);
    chk("t1_idle_busy", uart_tx_busy, 0);

    // Two bytes on consecutive cycles: frames must run back-to-back.
    s = cyc;
    wr_data = 8'h55; wr_en = 1'b1; tick();
    wr_data = 8'h0F; tick(); wr_en = 1'b0;
    chk("t2_count_pop_and_write", fifo_count, 1);
    ticks(100);
    decode(s, cyc);
    chk("t2_frames", rx_n, 2);
    chk("t2_byte0", rx_bytes[0], 8'h55);
    chk("t2_byte1", rx_bytes[1], 8'h0F);
    chk("t2_no_gap", rx_start[1], rx_start[0] + FR);
    chk("t2_badframe", rx_badframe, 0);
    chk("t2_busy_total", count_hi(s, cyc, 0), 80);
    chk("t2_busy_contiguous", count_hi(rx_start[0], rx_start[0] + 2 * FR, 0), 80);

    // Overflow: ten writes from idle, the tenth lands on a full FIFO.
    s = cyc;
    for (int k = 1; k <= 10; k++) begin
      wr_data = 8'(k); wr_en = 1'b1; tick();
      if (k == 8) chk("t3_not_full_after_8", fifo_full, 0);
      if (k == 9) begin
        chk("t3_full_after_9", fifo_full, 1);
        chk("t3_count_after_9", fifo_count, 8);
      end
      if (k == 10) chk("t3_count_after_drop", fifo_count, 8);
    end
    wr_en = 1'b0;
    ticks(9 * FR + 20);
    decode(s, cyc);
    chk("t3_frames", rx_n, 9);
    mism = 0;
    for (int k = 0; k < 9; k++) if (rx_bytes[k] !== 8'(k + 1)) mism++;
    chk("t3_byte_order_mismatches", mism, 0);
    chk("t3_badframe", rx_badframe, 0);
    chk("t3_empty_at_end", fifo_empty, 1);

    // Write on the same edge as a STOP-end pop with one byte queued.
    s = cyc;
    wr_data = 8'h3C; wr_en = 1'b1; tick(); wr_en = 1'b0;
    tick();
    chk("t4_first_start", uart_tx, 0);
    ticks(5);
    wr_data = 8'hC3; wr_en = 1'b1; tick(); wr_en = 1'b0;
    ticks(33);
    chk("t4_count_before_edge", fifo_count, 1);
    wr_data = 8'h96; wr_en = 1'b1; tick(); wr_en = 1'b0;
    chk("t4_count_same_edge", fifo_count, 1);
    chk("t4_second_start", uart_tx, 0);
    ticks(2 * FR + 20);
    decode(s, cyc);
    chk("t4_frames", rx_n, 3);
    chk("t4_byte0", rx_bytes[0], 8'h3C);
    chk("t4_byte1", rx_bytes[1], 8'hC3);
    chk("t4_byte2", rx_bytes[2], 8'h96);
    chk("t4_no_gap", rx_start[1], rx_start[0] + FR);

    // Asynchronous reset in the middle of a data bit with three bytes queued.
    for (int k = 0; k < 4; k++) begin
      wr_data = 8'(k * 17); wr_en = 1'b1; tick();
    end
    wr_en = 1'b0;
    chk("t5_queued", fifo_count, 3);
    ticks(8);
    chk("t5_mid_data_low", uart_tx, 0);
    reset = 1'b1;
    #1;
    chk("t5_rst_tx", uart_tx, 1);
    chk("t5_rst_busy", uart_tx_busy, 0);
    chk("t5_rst_count", fifo_count, 0);
    chk("t5_rst_empty", fifo_empty, 1);
    chk("t5_rst_next_bit", next_bit, 0);
    #2;
    reset = 1'b0;
    tick();
    s = cyc;
    ticks(100);
    chk("t5_no_frames_low_cycles", count_hi(s, cyc, 2), 0);
    chk("t5_no_busy_cycles", count_hi(s, cyc, 0), 0);
    s = cyc;
    wr_data = 8'h42; wr_en = 1'b1; tick(); wr_en = 1'b0;
    tick();
    chk("t5_new_start", uart_tx, 0);
    ticks(FR + 10);
    decode(s, cyc);
    chk("t5_new_frames", rx_n, 1);
    chk("t5_new_byte", rx_bytes[0], 8'h42);

    // Stream 20 bytes through the FIFO so both pointers wrap.
    s = cyc;
    v = 0;
    guard = 0;
    maxocc = 0;
    while (v < 20 && guard < 2000) begin
      if (fifo_full === 1'b0) begin
        wr_en = 1'b1; wr_data = 8'(v); v++;
      end else begin
        wr_en = 1'b0;
      end
      tick();
      if (int'(fifo_count) > maxocc) maxocc = int'(fifo_count);
      guard++;
    end
    wr_en = 1'b0;
    chk("t6_all_written", v, 20);
    chk("t6_max_occupancy", maxocc, DEPTH);
    ticks(DEPTH * FR + 60);
    decode(s, cyc);
    chk("t6_frames", rx_n, 20);
    mism = 0;
    for (int k = 0; k < 20; k++) if (rx_bytes[k] !== 8'(k)) mism++;
    chk("t6_byte_order_mismatches", mism, 0);
    chk("t6_badframe", rx_badframe, 0);
    chk("t6_idle_busy", uart_tx_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Transmit side of the MiniCPU UART peripheral; sits directly upstream of the serial line `uart_tx`.
- The `uart_display` bench monitor consumes that line.
- Accepts bytes from the CPU store path into a small FIFO and serialises them as 8N1 frames (LSB first) at a fixed clocks-per-bit rate.
- Exports `uart_tx_busy` and a per-bit `next_bit` strobe, which the bench monitor uses as its reset and sampling clock.

Parameters:
- CLK_DIV, 16, clk cycles per serial bit period; minimum 2.
- FIFO_DEPTH, 8, transmit FIFO entries; power of two, minimum 2.
- CNT_W, $clog2(FIFO_DEPTH+1), width of fifo_count.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- wr_en  input  1  CPU write strobe, one byte per cycle.
- wr_data  input  8  byte to transmit.
- fifo_full  output  1  FIFO holds FIFO_DEPTH entries.
- fifo_empty  output  1  FIFO holds 0 entries.
- fifo_count  output  CNT_W  current FIFO occupancy.
- uart_tx  output  1  serial line; idle high.
- uart_tx_busy  output  1  high from start bit through end of last stop bit.
- next_bit  output  1  one-cycle strobe on the last cycle of every bit period.

Behaviour:
- Interface (already decided): one clock, `clk`; reset `reset` is asynchronous and active-high. While `reset` is asserted:
  - uart_tx=1, uart_tx_busy=0, next_bit=0.
  - fifo_empty=1, fifo_full=0, fifo_count=0.
  - State = IDLE; read/write pointers and baud counter = 0.
- Reset mid-frame aborts the frame at once: line returns high, FIFO contents are discarded.
- FIFO, circular, pointers wrap modulo FIFO_DEPTH:
  - A write is accepted when wr_en=1 and fifo_full=0 (pre-edge value).
  - A write while full is silently dropped; there is no error flag.
  - Pop (by the FSM) and write on the same edge: count unchanged, both happen.
  - A write while full is dropped even when a pop occurs on the same edge.
  - No same-cycle bypass: a byte written at edge k is popped no earlier than edge k+1.
- Baud counter:
  - Counts 0..CLK_DIV-1 in START/DATA/STOP.
  - Reloads to 0 on wrap and on entry to START.
  - next_bit is registered, high for the cycle in which counter==CLK_DIV-1 in a non-IDLE state: exactly 10 pulses per frame.
- FSM (IDLE, START, DATA, STOP):
  - IDLE: uart_tx=1. If fifo_empty=0: pop head into shift register, go to START, uart_tx<=0, busy<=1 on the same edge.
  - START: hold 0 for CLK_DIV cycles, then go to DATA, driving shift[0].
  - DATA: 8 bit periods, LSB first. Shift right and increment the 3-bit index on each period end. After bit 7, go to STOP with uart_tx<=1.
  - STOP: hold 1 for CLK_DIV cycles. At period end:
    - FIFO non-empty: pop and go directly to START (no idle gap; busy stays 1).
    - FIFO empty: go to IDLE, busy<=0.
- Timing:
  - Frame = 10*CLK_DIV cycles.
  - Latency from an accepted write into an idle, empty block to the start-bit falling edge = 2 edges (write edge plus pop edge).
- All outputs are registered; no combinational path from wr_en to uart_tx.

Test Plan:
- Reset, CLK_DIV=4, write 0xA5 once. Required:
  - uart_tx goes low one edge after the write edge.
  - Line sequence is 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles.
  - busy high for exactly 40 cycles; 10 next_bit pulses.
  - Line returns to idle high.
- Write 0x55 then 0x0F on consecutive cycles. Required:
  - Two frames back-to-back, stop bit of the first immediately followed by start bit of the second.
  - busy continuously high for 80 cycles (CLK_DIV=4).
- Overflow, FIFO_DEPTH=8: write 10 bytes 0x01..0x0A on consecutive cycles from idle. Required:
  - fifo_full asserted after the 9th write edge.
  - 0x0A dropped.
  - Exactly 9 frames transmitted, 0x01..0x09 in order.
- Simultaneous pop/write: with one byte queued at a STOP period end, write a new byte on that same edge. Required:
  - fifo_count stays 1.
  - Both bytes transmitted in order.
- Async reset pulse mid-DATA of a frame with 3 bytes queued. Required:
  - uart_tx=1, busy=0, fifo_count=0 immediately.
  - No further frames after reset release until a new write.
- Pointer wrap: stream 20 bytes (0x00..0x13), keeping occupancy ≤ FIFO_DEPTH. Required: all 20 received intact and in order by the monitor.
